// File: rtl/unified_mem_arbiter_if.sv
// Signal bundle shared by the CPU fetch/data ports, the arbiter and the unified memory.
// The slave modport is the arbiter's view; the master modport is the CPU plus memory view.
interface unified_mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic [3:0]  d_wen;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        oob_err;
  logic        m_en;
  logic [3:0]  m_wen;
  logic [29:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wen, d_wdata, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, oob_err,
           m_en, m_wen, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_wen, d_wdata, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, oob_err,
           m_en, m_wen, m_addr, m_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Per-cycle arbiter sharing one single-port word memory between instruction fetch and data
// access, with a read-tag pipeline that steers returning data back to the issuing port.
module unified_mem_arbiter #(
  parameter int MEM_WORDS    = 1024,
  parameter int MEM_LAT      = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  unified_mem_arbiter_if.slave bus
);

  localparam int              SW         = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [31:0]     OOB_LIMIT  = 32'(4 * MEM_WORDS);
  localparam logic [31:0]     OOB_DATA   = 32'hdead_beef;

  logic [SW-1:0]      streak_r;
  logic               i_gnt_s;
  logic               d_gnt_s;
  logic               gnt_s;
  logic               oob_s;
  logic               rd_issue_s;
  logic [31:0]        addr_s;
  logic [MEM_LAT-1:0] tag_valid_r;
  logic [MEM_LAT-1:0] tag_src_r;
  logic [MEM_LAT-1:0] tag_oob_r;
  logic               oob_err_r;
  logic               ret_valid_s;
  logic               ret_src_s;
  logic [31:0]        ret_data_s;

  // Grant selection: data wins unless it has hit its streak limit against a waiting fetch.
  always_comb begin
    i_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    if (!rst_n) begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end else if (bus.d_req && bus.i_req) begin
      if (streak_r == STREAK_MAX) begin
        i_gnt_s = 1'b1;
      end else begin
        d_gnt_s = 1'b1;
      end
    end else if (bus.d_req) begin
      d_gnt_s = 1'b1;
    end else if (bus.i_req) begin
      i_gnt_s = 1'b1;
    end else begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end
  end

  // Address mux, range check and read classification of the granted request.
  always_comb begin
    addr_s = 32'h0000_0000;
    if (d_gnt_s) begin
      addr_s = bus.d_addr;
    end else if (i_gnt_s) begin
      addr_s = bus.i_addr;
    end else begin
      addr_s = 32'h0000_0000;
    end
    gnt_s      = i_gnt_s | d_gnt_s;
    oob_s      = gnt_s && (addr_s >= OOB_LIMIT);
    rd_issue_s = i_gnt_s || (d_gnt_s && (bus.d_wen == 4'b0000));
  end

  // Memory-side issue; out-of-range accesses are granted but never reach the memory.
  always_comb begin
    bus.i_gnt   = i_gnt_s;
    bus.d_gnt   = d_gnt_s;
    bus.m_en    = gnt_s && !oob_s;
    bus.m_addr  = addr_s[31:2];
    bus.m_wen   = 4'b0000;
    bus.m_wdata = 32'h0000_0000;
    if (d_gnt_s && !oob_s) begin
      bus.m_wen   = bus.d_wen;
      bus.m_wdata = bus.d_wdata;
    end else begin
      bus.m_wen   = 4'b0000;
      bus.m_wdata = 32'h0000_0000;
    end
  end

  // Consecutive data-grant counter, only meaningful while a fetch is waiting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak_r <= {SW{1'b0}};
    end else if (!bus.i_req || i_gnt_s) begin
      streak_r <= {SW{1'b0}};
    end else if (d_gnt_s && (streak_r != STREAK_MAX)) begin
      streak_r <= streak_r + {{(SW-1){1'b0}}, 1'b1};
    end else begin
      streak_r <= streak_r;
    end
  end

  // Read tag shift register aligned with the memory latency; writes leave a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_valid_r <= {MEM_LAT{1'b0}};
      tag_src_r   <= {MEM_LAT{1'b0}};
      tag_oob_r   <= {MEM_LAT{1'b0}};
      oob_err_r   <= 1'b0;
    end else begin
      tag_valid_r[0] <= rd_issue_s;
      tag_src_r[0]   <= d_gnt_s;
      tag_oob_r[0]   <= oob_s;
      for (int k = 1; k < MEM_LAT; k++) begin
        tag_valid_r[k] <= tag_valid_r[k-1];
        tag_src_r[k]   <= tag_src_r[k-1];
        tag_oob_r[k]   <= tag_oob_r[k-1];
      end
      oob_err_r <= oob_s;
    end
  end

  // Response routing; rdata is forced to zero whenever its rvalid is low.
  always_comb begin
    ret_valid_s  = rst_n && tag_valid_r[MEM_LAT-1];
    ret_src_s    = tag_src_r[MEM_LAT-1];
    ret_data_s   = tag_oob_r[MEM_LAT-1] ? OOB_DATA : bus.m_rdata;
    bus.i_rvalid = ret_valid_s && !ret_src_s;
    bus.d_rvalid = ret_valid_s && ret_src_s;
    bus.oob_err  = rst_n && oob_err_r;
    if (bus.i_rvalid) begin
      bus.i_rdata = ret_data_s;
    end else begin
      bus.i_rdata = 32'h0000_0000;
    end
    if (bus.d_rvalid) begin
      bus.d_rdata = ret_data_s;
    end else begin
      bus.d_rdata = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: one arbiter with MEM_LAT=1 and one with MEM_LAT=3, each behind a word memory
// preloaded with 0xA000_0000+index and 0xB000_0000+index respectively.
module tb_unified_mem_arbiter;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  unified_mem_arbiter_if bus1 ();
  unified_mem_arbiter_if bus3 ();

  unified_mem_arbiter #(.MEM_WORDS(1024), .MEM_LAT(1), .MAX_D_STREAK(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );
  unified_mem_arbiter #(.MEM_WORDS(1024), .MEM_LAT(3), .MAX_D_STREAK(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem1 [0:1023];
  logic [31:0] rd1;
  logic [31:0] mem3 [0:1023];
  logic [31:0] p3 [0:2];

  // Memory models: the pattern is reloaded while reset is held.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem1[i] <= 32'hA000_0000 + 32'(i);
    end else if (bus1.m_en) begin
      if (bus1.m_wen == 4'b0000) rd1 <= mem1[bus1.m_addr[9:0]];
      else for (int b = 0; b < 4; b++)
        if (bus1.m_wen[b]) mem1[bus1.m_addr[9:0]][8*b +: 8] <= bus1.m_wdata[8*b +: 8];
    end
  end
  assign bus1.m_rdata = rd1;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem3[i] <= 32'hB000_0000 + 32'(i);
    end else if (bus3.m_en && (bus3.m_wen == 4'b0000)) begin
      p3[0] <= mem3[bus3.m_addr[9:0]];
    end
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus3.m_rdata = p3[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus1.i_req = 1'b0; bus1.i_addr = 32'h0; bus1.d_req = 1'b0; bus1.d_addr = 32'h0;
    bus1.d_wen = 4'h0; bus1.d_wdata = 32'h0;
    bus3.i_req = 1'b0; bus3.i_addr = 32'h0; bus3.d_req = 1'b0; bus3.d_addr = 32'h0;
    bus3.d_wen = 4'h0; bus3.d_wdata = 32'h0;
  endtask

  logic        exp_ig;
  logic        exp_dg;
  logic        exp_iv;
  logic        exp_dv;
  logic [31:0] exp_id;
  logic [31:0] exp_dd;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_all();
    rst_n = 1'b0;
    bus1.i_req = 1'b1;
    bus1.d_req = 1'b1;
    step(); step();
    @(negedge clk);
    check_eq("rst_i_gnt",  32'(bus1.i_gnt), 32'h0);
    check_eq("rst_d_gnt",  32'(bus1.d_gnt), 32'h0);
    check_eq("rst_m_en",   32'(bus1.m_en), 32'h0);
    check_eq("rst_rvalid", 32'({bus1.i_rvalid, bus1.d_rvalid, bus1.oob_err}), 32'h0);

    // Fetch only at address 0
    step();
    rst_n = 1'b1;
    idle_all();
    bus1.i_req = 1'b1;
    @(negedge clk);
    check_eq("t1_i_gnt", 32'(bus1.i_gnt), 32'h1);
    check_eq("t1_d_gnt", 32'(bus1.d_gnt), 32'h0);
    check_eq("t1_m_en",  32'(bus1.m_en), 32'h1);
    check_eq("t1_m_addr", 32'(bus1.m_addr), 32'h0);
    step();
    idle_all();
    @(negedge clk);
    check_eq("t1_i_rvalid", 32'(bus1.i_rvalid), 32'h1);
    check_eq("t1_i_rdata",  bus1.i_rdata, 32'hA000_0000);
    check_eq("t1_d_rvalid", 32'(bus1.d_rvalid), 32'h0);

    // Both requesting for 12 cycles: D,D,D,D,I repeating
    for (int k = 0; k < 12; k++) begin
      step();
      bus1.i_req = 1'b1; bus1.i_addr = 32'h4;
      bus1.d_req = 1'b1; bus1.d_addr = 32'h8;
      exp_ig = (k % 5 == 4);
      exp_iv = (k > 0) && ((k - 1) % 5 == 4);
      exp_dv = (k > 0) && ((k - 1) % 5 != 4);
      @(negedge clk);
      check_eq($sformatf("t2_i_gnt_%0d", k), 32'(bus1.i_gnt), 32'(exp_ig));
      check_eq($sformatf("t2_d_gnt_%0d", k), 32'(bus1.d_gnt), 32'(!exp_ig));
      check_eq($sformatf("t2_i_rv_%0d", k), 32'(bus1.i_rvalid), 32'(exp_iv));
      check_eq($sformatf("t2_d_rv_%0d", k), 32'(bus1.d_rvalid), 32'(exp_dv));
    end
    step();
    idle_all();
    step();

    // Store then load of the same word
    bus1.d_req = 1'b1; bus1.d_addr = 32'h100; bus1.d_wen = 4'hF; bus1.d_wdata = 32'h1234_5678;
    @(negedge clk);
    check_eq("t3_st_gnt",   32'(bus1.d_gnt), 32'h1);
    check_eq("t3_st_m_wen", 32'(bus1.m_wen), 32'hF);
    check_eq("t3_st_m_addr", 32'(bus1.m_addr), 32'h40);
    check_eq("t3_st_m_wdata", bus1.m_wdata, 32'h1234_5678);
    step();
    bus1.d_wen = 4'h0;
    @(negedge clk);
    check_eq("t3_ld_gnt",   32'(bus1.d_gnt), 32'h1);
    check_eq("t3_ld_m_wen", 32'(bus1.m_wen), 32'h0);
    check_eq("t3_st_no_rv", 32'({bus1.i_rvalid, bus1.d_rvalid}), 32'h0);
    step();
    idle_all();
    @(negedge clk);
    check_eq("t3_d_rvalid", 32'(bus1.d_rvalid), 32'h1);
    check_eq("t3_d_rdata",  bus1.d_rdata, 32'h1234_5678);
    check_eq("t3_i_rvalid", 32'(bus1.i_rvalid), 32'h0);

    // Out-of-range load, last in-range word, out-of-range store
    step();
    bus1.d_req = 1'b1; bus1.d_addr = 32'h1000;
    @(negedge clk);
    check_eq("t4_gnt",  32'(bus1.d_gnt), 32'h1);
    check_eq("t4_m_en", 32'(bus1.m_en), 32'h0);
    check_eq("t4_oob_early", 32'(bus1.oob_err), 32'h0);
    step();
    bus1.d_addr = 32'hFFC;
    @(negedge clk);
    check_eq("t4_oob_err", 32'(bus1.oob_err), 32'h1);
    check_eq("t4_d_rvalid", 32'(bus1.d_rvalid), 32'h1);
    check_eq("t4_d_rdata", bus1.d_rdata, 32'hDEAD_BEEF);
    check_eq("t4_edge_m_en", 32'(bus1.m_en), 32'h1);
    step();
    bus1.d_addr = 32'h1000; bus1.d_wen = 4'hF; bus1.d_wdata = 32'h5555_AAAA;
    @(negedge clk);
    check_eq("t4_edge_oob", 32'(bus1.oob_err), 32'h0);
    check_eq("t4_edge_rdata", bus1.d_rdata, 32'hA000_03FF);
    check_eq("t4_wr_gnt", 32'(bus1.d_gnt), 32'h1);
    check_eq("t4_wr_m_wen", 32'({bus1.m_en, bus1.m_wen}), 32'h0);
    step();
    idle_all();
    @(negedge clk);
    check_eq("t4_wr_oob_err", 32'(bus1.oob_err), 32'h1);
    check_eq("t4_wr_no_rv", 32'(bus1.d_rvalid), 32'h0);
    step();
    @(negedge clk);
    check_eq("t4_oob_clear", 32'(bus1.oob_err), 32'h0);

    // MEM_LAT=3: alternating I/D reads
    for (int k = 0; k < 8; k++) begin
      step();
      idle_all();
      exp_id = 32'h0;
      exp_dd = 32'h0;
      case (k)
        0: begin bus3.i_req = 1'b1; bus3.i_addr = 32'h10; end
        1: begin bus3.d_req = 1'b1; bus3.d_addr = 32'h20; end
        2: begin bus3.i_req = 1'b1; bus3.i_addr = 32'h30; end
        3: begin bus3.d_req = 1'b1; bus3.d_addr = 32'h40; exp_id = 32'hB000_0004; end
        4: exp_dd = 32'hB000_0008;
        5: exp_id = 32'hB000_000C;
        6: exp_dd = 32'hB000_0010;
        default: ;
      endcase
      exp_ig = (k == 0) || (k == 2);
      exp_dg = (k == 1) || (k == 3);
      @(negedge clk);
      check_eq($sformatf("t5_i_gnt_%0d", k), 32'(bus3.i_gnt), 32'(exp_ig));
      check_eq($sformatf("t5_d_gnt_%0d", k), 32'(bus3.d_gnt), 32'(exp_dg));
      check_eq($sformatf("t5_i_rv_%0d", k), 32'(bus3.i_rvalid), 32'(exp_id != 32'h0));
      check_eq($sformatf("t5_d_rv_%0d", k), 32'(bus3.d_rvalid), 32'(exp_dd != 32'h0));
      check_eq($sformatf("t5_i_rd_%0d", k), bus3.i_rdata, exp_id);
      check_eq($sformatf("t5_d_rd_%0d", k), bus3.d_rdata, exp_dd);
    end

    // Two reads in flight, then reset before they return
    step();
    bus3.i_req = 1'b1; bus3.i_addr = 32'h8;
    step();
    idle_all();
    bus3.d_req = 1'b1; bus3.d_addr = 32'hC;
    step();
    rst_n = 1'b0;
    bus3.i_req = 1'b1;
    bus3.d_req = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_gnt", 32'({bus3.i_gnt, bus3.d_gnt}), 32'h0);
    check_eq("t6_rst_m", 32'({bus3.m_en, bus3.m_wen}), 32'h0);
    check_eq("t6_rst_m_addr", 32'(bus3.m_addr), 32'h0);
    check_eq("t6_rst_rv", 32'({bus3.i_rvalid, bus3.d_rvalid, bus3.oob_err}), 32'h0);
    step();
    rst_n = 1'b1;
    idle_all();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("t6_no_rv_%0d", k), 32'({bus3.i_rvalid, bus3.d_rvalid}), 32'h0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
